// File: rtl/jk_moore_bank_pkg.sv
// rtl/jk_moore_bank_pkg.sv - shared types and helpers for the jk_moore_bank controller
//
// Purpose : channel state encoding (2-bit Moore states) and a popcount helper
//           used to form the aggregate "channels on" count.
// Ports   : none (package).
// Options : none here; JK_MOORE_BANK_STICKY_EN is handled in the cell, top and interface.

package jk_moore_bank_pkg;

  // Widest channel bank the popcount helper can count.
  localparam int MAX_CH = 32;

  typedef enum logic [1:0] {
    ST_OFF    = 2'd0,
    ST_ARM    = 2'd1,
    ST_ON     = 2'd2,
    ST_DISARM = 2'd3
  } jk_state_e;

  function automatic int unsigned popcount(input logic [MAX_CH-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < MAX_CH; i++) begin
      n += {31'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/jk_moore_bank_if.sv
// rtl/jk_moore_bank_if.sv - request/status bundle for the jk_moore_bank controller
//
// Purpose : groups the per-channel set/clear requests and the status outputs.
// Signals : j, k        per-channel set / clear requests (CH bits)
//           clr         per-channel sticky clear (CH bits, only with JK_MOORE_BANK_STICKY_EN)
//           out         per-channel Moore output (high in ON or DISARM)
//           rise, fall  per-channel one-cycle entry pulses
//           on_count    population count of out
// Modports: master drives the requests, slave is the controller.

interface jk_moore_bank_if #(
  parameter int CH = 4
);
  localparam int SUM_W = $clog2(CH + 1);

  logic [CH-1:0]    j;
  logic [CH-1:0]    k;
`ifdef JK_MOORE_BANK_STICKY_EN
  logic [CH-1:0]    clr;
`endif
  logic [CH-1:0]    out;
  logic [CH-1:0]    rise;
  logic [CH-1:0]    fall;
  logic [SUM_W-1:0] on_count;

`ifdef JK_MOORE_BANK_STICKY_EN
  modport master (output j, k, clr, input out, rise, fall, on_count);
  modport slave  (input j, k, clr, output out, rise, fall, on_count);
`else
  modport master (output j, k, input out, rise, fall, on_count);
  modport slave  (input j, k, output out, rise, fall, on_count);
`endif

endinterface

// File: rtl/jk_moore_cell.sv
// rtl/jk_moore_cell.sv - one J/K Moore on/off channel with dwell debounce
//
// Purpose : OFF -> ARM -> ON -> DISARM -> OFF; a request must persist for
//           DWELL consecutive cycles in ARM/DISARM before the change commits.
// Ports   : clk, rst_n    clock and synchronous active-low reset
//           j             set request
//           k             clear request (absent with JK_MOORE_BANK_STICKY_EN)
//           clr           sticky clear request (only with JK_MOORE_BANK_STICKY_EN)
//           out           registered Moore output, high in ON or DISARM
//           rise, fall    registered one-cycle pulses on entering ON / OFF
//           out_nxt       value out takes at the next edge (feeds the bank count)
// Options : JK_MOORE_BANK_STICKY_EN - only clr can clear an ON channel.

module jk_moore_cell
  import jk_moore_bank_pkg::*;
#(
  parameter int DWELL = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic j,
`ifdef JK_MOORE_BANK_STICKY_EN
  input  logic clr,
`else
  input  logic k,
`endif
  output logic out,
  output logic rise,
  output logic fall,
  output logic out_nxt
);

  localparam int CNT_W = $clog2(DWELL + 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(DWELL);

  jk_state_e        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             clear_req;

`ifdef JK_MOORE_BANK_STICKY_EN
  assign clear_req = clr;
`else
  assign clear_req = k;
`endif

  // cnt counts cycles the pending request has been seen, starting at 1 on
  // entry to ARM/DISARM; commit happens on the cycle it already equals DWELL,
  // so it saturates at DWELL and never wraps.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_OFF: begin
        if (j) begin
          state_nxt = ST_ARM;
          cnt_nxt   = CNT_ONE;
        end else begin
          cnt_nxt   = '0;
        end
      end
      ST_ARM: begin
        if (!j) begin
          state_nxt = ST_OFF;
          cnt_nxt   = '0;
        end else if (cnt == CNT_TOP) begin
          state_nxt = ST_ON;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt   = cnt + CNT_ONE;
        end
      end
      ST_ON: begin
        if (clear_req) begin
          state_nxt = ST_DISARM;
          cnt_nxt   = CNT_ONE;
        end else begin
          cnt_nxt   = '0;
        end
      end
      ST_DISARM: begin
        if (!clear_req) begin
          state_nxt = ST_ON;
          cnt_nxt   = '0;
        end else if (cnt == CNT_TOP) begin
          state_nxt = ST_OFF;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt   = cnt + CNT_ONE;
        end
      end
      default: begin
        state_nxt = ST_OFF;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign out_nxt = (state_nxt == ST_ON) || (state_nxt == ST_DISARM);

  // Outputs are registered alongside the state so they line up with the
  // cycle in which the state register shows the newly entered state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_OFF;
      cnt   <= '0;
      out   <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      out   <= out_nxt;
      rise  <= (state == ST_ARM) && (state_nxt == ST_ON);
      fall  <= (state == ST_DISARM) && (state_nxt == ST_OFF);
    end
  end

endmodule

// File: rtl/jk_moore_bank.sv
// rtl/jk_moore_bank.sv - bank of CH independent J/K Moore on/off channels
//
// Purpose : instantiates CH jk_moore_cell channels and a registered count of
//           channels whose output is high.
// Ports   : clk, rst_n    clock and synchronous active-low reset
//           bus           jk_moore_bank_if slave: j, k, (clr), out, rise, fall, on_count
// Options : JK_MOORE_BANK_STICKY_EN - adds clr; only clr clears an ON channel.
// Limits  : CH must not exceed jk_moore_bank_pkg::MAX_CH.

module jk_moore_bank
  import jk_moore_bank_pkg::*;
#(
  parameter int CH    = 4,
  parameter int DWELL = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  jk_moore_bank_if.slave  bus
);

  localparam int SUM_W = $clog2(CH + 1);

  logic [CH-1:0]    out_v;
  logic [CH-1:0]    rise_v;
  logic [CH-1:0]    fall_v;
  logic [CH-1:0]    out_nxt_v;
  logic [SUM_W-1:0] on_count_q;

  for (genvar i = 0; i < CH; i++) begin : g_ch
    jk_moore_cell #(
      .DWELL (DWELL)
    ) u_cell (
      .clk     (clk),
      .rst_n   (rst_n),
      .j       (bus.j[i]),
`ifdef JK_MOORE_BANK_STICKY_EN
      .clr     (bus.clr[i]),
`else
      .k       (bus.k[i]),
`endif
      .out     (out_v[i]),
      .rise    (rise_v[i]),
      .fall    (fall_v[i]),
      .out_nxt (out_nxt_v[i])
    );
  end

  // Counting the cells' next outputs keeps on_count in the same cycle as out
  // while still being a register with no path from j/k to the port.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      on_count_q <= '0;
    end else begin
      on_count_q <= SUM_W'(popcount(MAX_CH'(out_nxt_v)));
    end
  end

  assign bus.out      = out_v;
  assign bus.rise     = rise_v;
  assign bus.fall     = fall_v;
  assign bus.on_count = on_count_q;

endmodule

// File: tb/tb_jk_moore_bank.sv
// tb/tb_jk_moore_bank.sv - directed self-checking bench for jk_moore_bank
//
// Purpose : directed vectors with hand-computed expectations, CH=4, DWELL=3.
// Options : JK_MOORE_BANK_STICKY_EN adds the sticky-clear scenario.

module tb_jk_moore_bank;

  localparam int CH    = 4;
  localparam int DWELL = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  jk_moore_bank_if #(.CH(CH)) bus ();

  jk_moore_bank #(
    .CH    (CH),
    .DWELL (DWELL)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] eo, input logic [3:0] er,
                           input logic [3:0] ef, input logic [2:0] ec);
    check({tag, ".out"},      {28'd0, bus.out},      {28'd0, eo});
    check({tag, ".rise"},     {28'd0, bus.rise},     {28'd0, er});
    check({tag, ".fall"},     {28'd0, bus.fall},     {28'd0, ef});
    check({tag, ".on_count"}, {29'd0, bus.on_count}, {29'd0, ec});
  endtask

  // Sample on the falling edge, after the rising edge has updated the DUT.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // The clear request: k in the default build; the shared scenarios drive
  // clr as well so their expectations hold in the sticky build too.
  task automatic set_clear(input logic [3:0] v);
    bus.k = v;
`ifdef JK_MOORE_BANK_STICKY_EN
    bus.clr = v;
`endif
  endtask

  initial begin
    logic [7:0] kpat;
    bus.j = 4'hF;
    bus.k = 4'h0;
`ifdef JK_MOORE_BANK_STICKY_EN
    bus.clr = 4'h0;
`endif
    rst_n = 1'b0;

    // Reset held two edges with j asserted: nothing leaves OFF.
    step();
    check_all("rst1", 4'h0, 4'h0, 4'h0, 3'd0);
    step();
    check_all("rst2", 4'h0, 4'h0, 4'h0, 3'd0);
    bus.j = 4'h0;
    rst_n = 1'b1;
    step();
    check_all("idle", 4'h0, 4'h0, 4'h0, 3'd0);

    // Dwell commit on ch0: ON after the 4th edge with j held.
    bus.j = 4'b0001;
    for (int c = 1; c <= 5; c++) begin
      step();
      check_all($sformatf("dwell%0d", c), (c >= 4) ? 4'b0001 : 4'b0000,
                (c == 4) ? 4'b0001 : 4'b0000, 4'h0, (c >= 4) ? 3'd1 : 3'd0);
    end
    bus.j = 4'h0;

    // Abort on ch1: j for two edges then dropped; no rise, stays off.
    bus.j = 4'b0010;
    for (int c = 1; c <= 5; c++) begin
      if (c == 3) bus.j = 4'h0;
      step();
      check_all($sformatf("abort%0d", c), 4'b0001, 4'h0, 4'h0, 3'd1);
    end

    // Clear with bounce on ch0: k 1,1,0 then held; fall on edge 7.
    kpat = 8'b1111_1011;
    for (int c = 1; c <= 8; c++) begin
      set_clear(kpat[c-1] ? 4'b0001 : 4'b0000);
      step();
      check_all($sformatf("bounce%0d", c), (c <= 6) ? 4'b0001 : 4'b0000, 4'h0,
                (c == 7) ? 4'b0001 : 4'b0000, (c <= 6) ? 3'd1 : 3'd0);
    end
    set_clear(4'h0);

    // All channels, j=k=1 toggle: ON on edge 4, then clear commits on edge 8.
    for (int c = 1; c <= 9; c++) begin
      bus.j = (c <= 4) ? 4'hF : 4'h0;
      set_clear((c <= 8) ? 4'hF : 4'h0);
      step();
      check_all($sformatf("all%0d", c), (c >= 4 && c <= 7) ? 4'hF : 4'h0,
                (c == 4) ? 4'hF : 4'h0, (c == 8) ? 4'hF : 4'h0,
                (c >= 4 && c <= 7) ? 3'd4 : 3'd0);
    end
    set_clear(4'h0);

    // Reset in the middle of a clear dwell on ch2: no fall pulse.
    bus.j = 4'b0100;
    for (int c = 1; c <= 4; c++) step();
    check_all("ch2on", 4'b0100, 4'b0100, 4'h0, 3'd1);
    bus.j = 4'h0;
    set_clear(4'b0100);
    step();
    step();
    check_all("ch2dis", 4'b0100, 4'h0, 4'h0, 3'd1);
    rst_n = 1'b0;
    step();
    check_all("rstdis", 4'h0, 4'h0, 4'h0, 3'd0);
    rst_n = 1'b1;
    set_clear(4'h0);
    step();
    check_all("rstdis_after", 4'h0, 4'h0, 4'h0, 3'd0);

    // Reset in the middle of an arm dwell on ch3 restarts the dwell.
    bus.j = 4'b1000;
    step();
    step();
    rst_n = 1'b0;
    step();
    check_all("rstarm", 4'h0, 4'h0, 4'h0, 3'd0);
    rst_n = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      step();
      check_all($sformatf("rearm%0d", c), (c == 4) ? 4'b1000 : 4'h0,
                (c == 4) ? 4'b1000 : 4'h0, 4'h0, (c == 4) ? 3'd1 : 3'd0);
    end
    bus.j = 4'h0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    check_all("clean", 4'h0, 4'h0, 4'h0, 3'd0);

`ifdef JK_MOORE_BANK_STICKY_EN
    // Sticky: k ignored in ON, only clr clears ch2.
    bus.j = 4'b0100;
    for (int c = 1; c <= 4; c++) step();
    bus.j = 4'h0;
    bus.k = 4'b0100;
    for (int c = 1; c <= 5; c++) begin
      step();
      check_all($sformatf("sticky_k%0d", c), 4'b0100, 4'h0, 4'h0, 3'd1);
    end
    bus.k = 4'h0;
    bus.clr = 4'b0100;
    for (int c = 1; c <= 4; c++) begin
      step();
      check_all($sformatf("sticky_clr%0d", c), (c <= 3) ? 4'b0100 : 4'h0, 4'h0,
                (c == 4) ? 4'b0100 : 4'h0, (c <= 3) ? 3'd1 : 3'd0);
    end
    bus.clr = 4'h0;
`endif

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
